switch_challenge_gen: RTL
=========================

// Module: switch_challenge_gen
// PURPOSE
//  Challenge side of the switch puzzle. Draws a pseudo-random switch type (2b) and colour (3b) from a free-running LFSR
//  on a debounced start press, holds them for the switch checker and shows them on the RGB / type LEDs.
//  Consumes the checker's boom/done and reports ARMED / SOLVED / EXPLODED. Clocked by the same 1 kHz Clk.
// PARAMETERS
//  DEB_CYCLES   200      start_btn must differ stably for > DEB_CYCLES clocks before it is accepted
//  BLINK_HALF   250      half-period of LED blink in Clk cycles (2 Hz at 1 kHz)
//  PRST_CYCLES  4        width of puzzle_rst pulse issued to the checker on arm
//  LFSR_SEED    16'hACE1 LFSR reset value; must be non-zero
// PORTS
//  Clk        in   1  1 kHz system clock
//  rst        in   1  asynchronous, active-high reset
//  start_btn  in   1  raw start push-button, asynchronous, bouncy
//  boom_in    in   1  checker fail flag, asynchronous to Clk (checker state updates on its own debounce strobe)
//  done_in    in   1  checker success flag, asynchronous to Clk
//  sw_type    out  2  latched challenge type, drives checker sw_type
//  color      out  3  latched challenge colour, drives checker color; bit2=R bit1=G bit0=B
//  puzzle_rst out  1  active-high reset pulse to checker
//  rgb_led    out  3  RGB indicator
//  type_led   out  4  one-hot of sw_type
//  armed      out  1  high in ACTIVE
//  solved     out  1  high in SOLVED
//  exploded   out  1  high in EXPLODED
// BEHAVIOUR
//  Reset: rst is asynchronous, active-high; clock Clk. On reset: state=IDLE, LFSR=LFSR_SEED, all outputs 0.
//  LFSR: 16b Fibonacci, taps 16,14,13,11; shifts every Clk in every state; if it ever reads 0, reload LFSR_SEED.
//  Start: start_btn -> 2-FF synchroniser -> debouncer; start_ev is a 1-cycle pulse on the accepted 0->1 edge.
//  boom_in, done_in: each passes a 2-FF synchroniser; FSM acts on the synchronised levels.
//  FSM:
//   IDLE     -> ARM on start_ev.
//   ARM      entry cycle latches sw_type=lfsr[1:0], color=lfsr[4:2]; puzzle_rst=1 for exactly PRST_CYCLES clocks,
//            then -> ACTIVE. Blink counter/phase cleared so ACTIVE begins in the ON phase.
//   ACTIVE   armed=1; rgb_led=color in ON phase, 0 in OFF phase; type_led=1<<sw_type.
//            boom_s=1 -> EXPLODED; else done_s=1 -> SOLVED. Both in same cycle -> EXPLODED (fail wins).
//   SOLVED   solved=1; rgb_led=3'b010 steady; type_led held.
//   EXPLODED exploded=1; rgb_led=3'b100 blinking at BLINK_HALF; type_led held.
//   SOLVED/EXPLODED -> ARM on start_ev (new challenge, new draw).
//  start_ev in ARM or ACTIVE is ignored (no re-draw mid-puzzle).
//  boom_s/done_s seen in IDLE/ARM are ignored; the puzzle_rst pulse clears them before ACTIVE.
//  Latency: start_ev -> ARM next edge; ACTIVE PRST_CYCLES+1 edges after start_ev.
//   boom_in/done_in rise -> exploded/solved high on the 3rd Clk edge (2 sync + 1 FSM).
//  Blink counter: 0..BLINK_HALF-1 then wraps and toggles phase; runs only in ACTIVE/EXPLODED.
//  sw_type/color stay stable from ARM entry until the next ARM entry; they never change during ACTIVE.
//  rst mid-operation: immediate return to IDLE; puzzle_rst driven 0 (checker shares rst).
// STRUCTURE
//  Shared package switch_pkg: state encoding (IDLE/ARM/ACTIVE/SOLVED/EXPLODED), colour bit-position constants,
//  RGB constants LED_RED=3'b100 and LED_GREEN=3'b010, sw_type width 2, color width 3.
//  Sub-module btn_debounce (params DEB_CYCLES): sync + stable counter; outputs clean level and rise pulse.
//  Top holds LFSR, FSM, puzzle_rst counter, blink counter, boom/done synchronisers.
// TESTING
//  1 Reset then idle 1000 cycles -> all outputs 0; LFSR != 0 every cycle; sequence matches bench tap-16/14/13/11 model.
//  2 start_btn bounces for 50 cycles then holds 1 for 150 -> no start_ev.
//    Holds 1 for 250 -> single start_ev; sw_type/color equal model lfsr[1:0]/[4:2] at the ARM entry cycle.
//    puzzle_rst high exactly 4 cycles; armed rises on edge 5.
//  3 In ACTIVE, color=3'b101 -> rgb_led 101 for 250 cycles, 000 for 250 cycles, repeating.
//    type_led = 1<<sw_type. Second start press -> ignored, outputs unchanged.
//  4 In ACTIVE raise done_in -> solved=1 and rgb_led=010 on 3rd edge.
//    Raise boom_in and done_in same cycle -> exploded=1 and solved=0.
//  5 EXPLODED, then start press -> new ARM with fresh draw and puzzle_rst pulse.
//    rst asserted mid-ARM -> outputs 0 asynchronously; IDLE after release.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types and constants for the switch puzzle: FSM state encoding,
// challenge field widths, LED colour constants and small decode helpers.
package switch_pkg;

    localparam int SW_TYPE_W   = 2;
    localparam int COLOR_W     = 3;
    localparam int TYPE_LED_W  = 4;
    localparam int LFSR_W      = 16;

    localparam int COLOR_R_BIT = 2;
    localparam int COLOR_G_BIT = 1;
    localparam int COLOR_B_BIT = 0;

    localparam logic [COLOR_W-1:0] LED_RED   = 3'b100;
    localparam logic [COLOR_W-1:0] LED_GREEN = 3'b010;
    localparam logic [COLOR_W-1:0] LED_OFF   = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        ACTIVE,
        SOLVED,
        EXPLODED
    } state_t;

    function automatic logic [TYPE_LED_W-1:0] type_onehot(input logic [SW_TYPE_W-1:0] t);
        return TYPE_LED_W'(1) << t;
    endfunction

    // The RGB LED pins are wired R,G,B high to low, matching the colour field layout.
    function automatic logic [COLOR_W-1:0] to_rgb(input logic [COLOR_W-1:0] c);
        return {c[COLOR_R_BIT], c[COLOR_G_BIT], c[COLOR_B_BIT]};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser followed by a stability counter.
// The clean level only follows the input after it has differed for more than DEB_CYCLES clocks.
module btn_debounce #(
    parameter int DEB_CYCLES = 200
) (
    input  logic Clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             btn_s;

    assign btn_s = sync[1];

    // Any return to the accepted level restarts the count, so bounces never accumulate.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            rise <= 1'b0;
            if (btn_s == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= btn_s;
                rise  <= btn_s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_challenge_gen.sv
// Challenge side of the switch puzzle: draws type/colour from a free-running LFSR on a
// debounced start press, pulses the checker reset, then tracks the checker's boom/done flags.
module switch_challenge_gen
    import switch_pkg::*;
#(
    parameter int          DEB_CYCLES  = 200,
    parameter int          BLINK_HALF  = 250,
    parameter int          PRST_CYCLES = 4,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                  Clk,
    input  logic                  rst,
    input  logic                  start_btn,
    input  logic                  boom_in,
    input  logic                  done_in,
    output logic [SW_TYPE_W-1:0]  sw_type,
    output logic [COLOR_W-1:0]    color,
    output logic                  puzzle_rst,
    output logic [COLOR_W-1:0]    rgb_led,
    output logic [TYPE_LED_W-1:0] type_led,
    output logic                  armed,
    output logic                  solved,
    output logic                  exploded
);

    localparam int PRST_W  = (PRST_CYCLES > 1) ? $clog2(PRST_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PRST_W-1:0]  PRST_LAST  = PRST_W'(PRST_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    state_t              state, next_state;
    logic [LFSR_W-1:0]   lfsr, lfsr_next;
    logic [PRST_W-1:0]   arm_cnt;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_phase;
    logic [1:0]          boom_sync, done_sync;
    logic                boom_s, done_s;
    logic                start_level, start_rise, start_ev;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_start_debounce (
        .Clk   (Clk),
        .rst   (rst),
        .btn   (start_btn),
        .level (start_level),
        .rise  (start_rise)
    );

    assign start_ev = start_rise & start_level;
    assign boom_s   = boom_sync[1];
    assign done_s   = done_sync[1];

    // Fibonacci taps 16,14,13,11; a zero state is forced back to the seed.
    always_comb begin
        lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        if (lfsr == '0) begin
            lfsr_next = LFSR_SEED;
        end
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            lfsr      <= LFSR_SEED;
            boom_sync <= '0;
            done_sync <= '0;
            state     <= IDLE;
        end else begin
            lfsr      <= lfsr_next;
            boom_sync <= {boom_sync[0], boom_in};
            done_sync <= {done_sync[0], done_in};
            state     <= next_state;
        end
    end

    // The draw uses the LFSR value of the ARM entry cycle and holds until the next ARM entry.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            sw_type <= '0;
            color   <= '0;
        end else if (next_state == ARM && state != ARM) begin
            sw_type <= lfsr_next[1:0];
            color   <= lfsr_next[4:2];
        end
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            arm_cnt <= '0;
        end else if (state == ARM) begin
            arm_cnt <= arm_cnt + 1'b1;
        end else begin
            arm_cnt <= '0;
        end
    end

    // Cleared outside ACTIVE/EXPLODED so ACTIVE always opens on a full ON half-period.
    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (state == ACTIVE || state == EXPLODED) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end else begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end
    end

    always_comb begin
        next_state = state;
        puzzle_rst = 1'b0;
        armed      = 1'b0;
        solved     = 1'b0;
        exploded   = 1'b0;
        rgb_led    = LED_OFF;
        type_led   = '0;
        unique case (state)
            IDLE: begin
                if (start_ev) next_state = ARM;
            end
            ARM: begin
                puzzle_rst = 1'b1;
                if (arm_cnt == PRST_LAST) next_state = ACTIVE;
            end
            ACTIVE: begin
                armed    = 1'b1;
                rgb_led  = blink_phase ? LED_OFF : to_rgb(color);
                type_led = type_onehot(sw_type);
                if (boom_s) begin
                    next_state = EXPLODED;
                end else if (done_s) begin
                    next_state = SOLVED;
                end
            end
            SOLVED: begin
                solved   = 1'b1;
                rgb_led  = LED_GREEN;
                type_led = type_onehot(sw_type);
                if (start_ev) next_state = ARM;
            end
            EXPLODED: begin
                exploded = 1'b1;
                rgb_led  = blink_phase ? LED_OFF : LED_RED;
                type_led = type_onehot(sw_type);
                if (start_ev) next_state = ARM;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
